xor_cipher_session_ctrl: RTL and testbench
==========================================

Name: xor_cipher_session_ctrl

Overview:
- Sequencer for the dual XOR cipher datapath.
- On a start request it loads an M-bit LFSR seed serially into the cipher core, then enables the core for a programmed number of bit cycles, then reports completion.
- It also contains the free-running transmit scheduler that raises a periodic report request toward the UART/signature path.
- It sits between the board-level wrapper (start/seed/len sources) and the cipher core.

Parameters:
- M, 32, seed/LFSR width in bits (≥2).
- TX_CNTR_PERIOD, 2000, clock cycles between transmit requests (≥2).
- LEN_W, 16, width of the run-length field.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  session request; sampled only in IDLE.
- abort  in  1  terminate the current session.
- seed  in  M  seed, captured on accepted start.
- len  in  LEN_W  number of RUN cycles, captured on accepted start.
- cfg_en  out  1  cipher core seed-shift enable.
- cfg_bit  out  1  serial seed bit, MSB first.
- run_en  out  1  cipher core advance enable.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle completion pulse.
- bit_cnt  out  LEN_W  RUN cycles completed in the current session.
- tx_req  out  1  transmit request, level.
- tx_ack  in  1  transmit acknowledge.
- tx_ovf  out  1  sticky: a period elapsed while tx_req was still pending.
- cipher_bit  in  1  cipher core output bit; used only with the optional feature.
- sig  out  M  session signature; see Optional Feature.

Behaviour:
- Reset state: IDLE. All outputs are 0, the internal seed shift register is 0, and the tx counter is 0.
- State machine: IDLE → LOAD → RUN → DONE → IDLE.
- IDLE:
  - start=1 captures seed into the shift register and len into len_q, clears bit_cnt, and moves to LOAD.
  - start in any other state is ignored.
- LOAD:
  - Lasts exactly M cycles. cfg_en=1 and cfg_bit = shreg[M-1] each cycle; shreg shifts left, filling 0.
  - After the M-th cycle the FSM goes to RUN, or directly to DONE if len_q=0.
- RUN:
  - run_en=1 and bit_cnt increments each cycle.
  - The FSM leaves after the cycle in which bit_cnt reaches len_q; run_en is therefore high for exactly len_q cycles.
- DONE: done=1 for one cycle, then IDLE. bit_cnt holds its final value until the next accepted start.
- Latency: with start accepted at edge 0:
  - cfg_en is high in cycles 1..M.
  - run_en is high in cycles M+1..M+len.
  - done is high in cycle M+len+1.
  - busy is high in cycles 1..M+len+1.
- cfg_en, run_en and done are registered and mutually exclusive.
- abort:
  - In LOAD or RUN, the FSM goes to IDLE on the next edge with no done pulse; cfg_en and run_en drop that same edge.
  - abort in IDLE or DONE has no effect. DONE completes normally.
  - abort together with start in IDLE: start wins.
- Transmit scheduler (independent of the FSM):
  - Counter runs 0..TX_CNTR_PERIOD-1 and wraps; the tick fires at TX_CNTR_PERIOD-1.
  - A tick sets tx_req. tx_ack=1 while tx_req=1 clears tx_req on the next edge.
  - Tick while tx_req=1 and tx_ack=0: tx_req stays 1 and tx_ovf is set.
  - Tick and tx_ack in the same cycle: tx_req stays 1 (new request) and tx_ovf is not set.
  - tx_ack while tx_req=0 is ignored. tx_ovf clears only on rst.
- Asynchronous rst mid-session returns everything to reset values immediately; the tx counter restarts from 0.

Optional Feature:
- Macro: XOR_CIPHER_CTRL_SIG_EN.
- Defined:
  - sig is a MISR cleared on accepted start.
  - Each RUN cycle: sig ← {sig[M-2:0], sig[M-1] ^ cipher_bit}.
  - Held outside RUN, including after abort.
- Undefined: sig is constant 0, cipher_bit is unused, and no MISR register is synthesized.

Test Plan:
- M=8, len=5, seed=8'hA5, start at cycle 0:
  - cfg_bit sequence 1,0,1,0,0,1,0,1 in cycles 1..8.
  - run_en high in cycles 9..13, done in cycle 14, bit_cnt=5.
  - busy high in cycles 1..14.
- len=0, M=8: no run_en; done in cycle 9.
- abort in the 3rd RUN cycle of a len=10 session: run_en low on the next edge, no done, bit_cnt=3, busy=0. A subsequent start proceeds normally.
- TX_CNTR_PERIOD=10:
  - tx_req rises after 10 cycles; tx_ack for 1 cycle clears it.
  - No ack for 2 periods: tx_ovf=1 and stays 1.
  - Ack coinciding with a tick: tx_req stays 1.
- With XOR_CIPHER_CTRL_SIG_EN, M=8, cipher_bit=1 for all 4 RUN cycles: sig=8'h0F. Without the macro, sig=0 throughout.
- Assert rst asynchronously mid-LOAD: all outputs 0 immediately, and a start issued after release reloads the full M bits.

Source files
------------

// File: rtl/xor_cipher_session_ctrl.sv
// Session sequencer for the XOR cipher core: serial seed load, N-cycle run, done pulse, plus TX report scheduler.
// Optional MISR signature over the cipher output when XOR_CIPHER_CTRL_SIG_EN is defined.
module xor_cipher_session_ctrl #(
  parameter int M              = 32,
  parameter int TX_CNTR_PERIOD = 2000,
  parameter int LEN_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [M-1:0]     seed,
  input  logic [LEN_W-1:0] len,
  output logic             cfg_en,
  output logic             cfg_bit,
  output logic             run_en,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] bit_cnt,
  output logic             tx_req,
  input  logic             tx_ack,
  output logic             tx_ovf,
  input  logic             cipher_bit,
  output logic [M-1:0]     sig
);

  localparam int LDW = $clog2(M);
  localparam int TXW = $clog2(TX_CNTR_PERIOD);
  localparam logic [LDW-1:0] LD_LAST = LDW'(M - 1);
  localparam logic [TXW-1:0] TX_LAST = TXW'(TX_CNTR_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [M-1:0]     shreg_q, shreg_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [LDW-1:0]   ld_cnt_q, ld_cnt_d;
  logic             cfg_en_q, run_en_q, done_q, busy_q;

  logic [TXW-1:0]   tx_cnt_q, tx_cnt_d;
  logic             tx_req_q, tx_req_d;
  logic             tx_ovf_q, tx_ovf_d;
  logic             tx_tick;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    len_d     = len_q;
    bit_cnt_d = bit_cnt_q;
    ld_cnt_d  = ld_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          shreg_d   = seed;
          len_d     = len;
          bit_cnt_d = '0;
          ld_cnt_d  = '0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        shreg_d  = {shreg_q[M-2:0], 1'b0};
        ld_cnt_d = ld_cnt_q + LDW'(1);
        if (abort) begin
          state_d = S_IDLE;
        end else if (ld_cnt_q == LD_LAST) begin
          state_d = (len_q == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // The aborted cycle still counts as a completed run cycle.
        bit_cnt_d = bit_cnt_q + LEN_W'(1);
        if (abort) begin
          state_d = S_IDLE;
        end else if (bit_cnt_d == len_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      len_q     <= '0;
      bit_cnt_q <= '0;
      ld_cnt_q  <= '0;
      cfg_en_q  <= 1'b0;
      run_en_q  <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      len_q     <= len_d;
      bit_cnt_q <= bit_cnt_d;
      ld_cnt_q  <= ld_cnt_d;
      cfg_en_q  <= (state_d == S_LOAD);
      run_en_q  <= (state_d == S_RUN);
      done_q    <= (state_d == S_DONE);
      busy_q    <= (state_d != S_IDLE);
    end
  end

  assign cfg_en  = cfg_en_q;
  assign cfg_bit = cfg_en_q & shreg_q[M-1];
  assign run_en  = run_en_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign bit_cnt = bit_cnt_q;

  // Free-running report scheduler, independent of the session FSM.
  assign tx_tick = (tx_cnt_q == TX_LAST);

  always_comb begin
    tx_cnt_d = tx_tick ? '0 : tx_cnt_q + TXW'(1);
    tx_req_d = tx_tick | (tx_req_q & ~tx_ack);
    tx_ovf_d = tx_ovf_q | (tx_tick & tx_req_q & ~tx_ack);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_cnt_q <= '0;
      tx_req_q <= 1'b0;
      tx_ovf_q <= 1'b0;
    end else begin
      tx_cnt_q <= tx_cnt_d;
      tx_req_q <= tx_req_d;
      tx_ovf_q <= tx_ovf_d;
    end
  end

  assign tx_req = tx_req_q;
  assign tx_ovf = tx_ovf_q;

`ifdef XOR_CIPHER_CTRL_SIG_EN
  logic [M-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (state_q == S_IDLE && start) begin
      sig_d = '0;
    end else if (state_q == S_RUN) begin
      sig_d = {sig_q[M-2:0], sig_q[M-1] ^ cipher_bit};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;
`else
  logic unused_cipher_bit;
  assign unused_cipher_bit = cipher_bit;
  assign sig = '0;
`endif

endmodule

// File: tb/tb_xor_cipher_session_ctrl.sv
// Randomized + directed bench for xor_cipher_session_ctrl (M=8, TX period 10) with a cycle-timeline reference model.
module tb_xor_cipher_session_ctrl;
  localparam int M  = 8;
  localparam int P  = 10;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst, start, abort, tx_ack, cipher_bit;
  logic [M-1:0]  seed;
  logic [LW-1:0] len;
  logic          cfg_en, cfg_bit, run_en, busy, done, tx_req, tx_ovf;
  logic [LW-1:0] bit_cnt;
  logic [M-1:0]  sig;

  xor_cipher_session_ctrl #(.M(M), .TX_CNTR_PERIOD(P), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .seed(seed), .len(len),
    .cfg_en(cfg_en), .cfg_bit(cfg_bit), .run_en(run_en), .busy(busy), .done(done),
    .bit_cnt(bit_cnt), .tx_req(tx_req), .tx_ack(tx_ack), .tx_ovf(tx_ovf),
    .cipher_bit(cipher_bit), .sig(sig)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ecnt  = 0;
  bit m_req = 1'b0;
  bit m_ovf = 1'b0;
  logic [M-1:0] m_sig = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int x, input int hi);
    if (x < 0) return 0;
    if (x > hi) return hi;
    return x;
  endfunction

  // One clock edge; the TX model follows the request/ack/tick rules using edge index since reset.
  task automatic cyc();
    bit tick;
    tick = ((ecnt % P) == P - 1);
    @(posedge clk);
    if (tick) begin
      if (m_req && !tx_ack) m_ovf = 1'b1;
      m_req = 1'b1;
    end else if (tx_ack) begin
      m_req = 1'b0;
    end
    ecnt++;
    #1;
    chk("tx_req", tx_req, m_req);
    chk("tx_ovf", tx_ovf, m_ovf);
  endtask

  task automatic idle_cycles(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      tx_ack = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      abort  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      cyc();
      chk("idle_busy", busy, 1'b0);
    end
    abort  = 1'b0;
    tx_ack = 1'b0;
  endtask

  // Runs one session; ab = cycle index of the abort (0 = none), counted from the accepting edge.
  task automatic session(input logic [M-1:0] sd, input int ln, input int ab, input bit all_ones,
                         output logic [M-1:0] cfgbits, output int runs, output int done_at,
                         output int busy_n, output int fin_cnt);
    int last, k_end, e_cnt;
    bit e_cfg, e_bit, e_run, e_done, e_busy, in_run;
    logic [M-1:0] e_sig;
    cfgbits = '0; runs = 0; done_at = 0; busy_n = 0;
    last  = (ab != 0) ? ab : M + ln + 1;
    k_end = last + 1;
    start = 1'b1; seed = sd; len = LW'(ln);
    abort  = 1'($urandom_range(0, 1));
    tx_ack = ($urandom_range(0, 3) == 0);
    cyc();
    m_sig = '0;
    for (int k = 1; k <= k_end; k++) begin
      e_busy = (k <= last);
      e_cfg  = (k <= M) && e_busy;
      e_bit  = 1'b0;
      if (e_cfg) e_bit = sd[M-k];
      e_run  = (k >= M + 1) && (k <= M + ln) && e_busy;
      e_done = (ab == 0) && (k == M + ln + 1);
      e_cnt  = (ab != 0 && k > ab) ? clampi(ab - M, ln) : clampi(k - M - 1, ln);
`ifdef XOR_CIPHER_CTRL_SIG_EN
      e_sig = m_sig;
`else
      e_sig = '0;
`endif
      chk($sformatf("cfg_en@%0d", k), cfg_en, e_cfg);
      chk($sformatf("cfg_bit@%0d", k), cfg_bit, e_bit);
      chk($sformatf("run_en@%0d", k), run_en, e_run);
      chk($sformatf("done@%0d", k), done, e_done);
      chk($sformatf("busy@%0d", k), busy, e_busy);
      chk($sformatf("bit_cnt@%0d", k), bit_cnt, LW'(e_cnt));
      chk($sformatf("sig@%0d", k), sig, e_sig);
      if (cfg_en) cfgbits = {cfgbits[M-2:0], cfg_bit};
      if (run_en) runs++;
      if (done) done_at = k;
      if (busy) busy_n++;
      // Drive cycle k: junk start while busy is ignored, aborts outside LOAD/RUN are no-ops.
      in_run     = (k >= M + 1) && (k <= M + ln) && (k <= last);
      cipher_bit = all_ones ? 1'b1 : 1'($urandom_range(0, 1));
      if (k == ab)                       abort = 1'b1;
      else if (ab == 0 && k == last)     abort = 1'($urandom_range(0, 1));
      else if (k > last)                 abort = 1'($urandom_range(0, 1));
      else                               abort = 1'b0;
      start  = (k <= last) ? 1'($urandom_range(0, 1)) : 1'b0;
      seed   = M'($urandom);
      len    = LW'($urandom);
      tx_ack = ($urandom_range(0, 3) == 0);
      if (in_run) m_sig = ((m_sig << 1) | (m_sig >> (M - 1))) ^ M'(cipher_bit);
      cyc();
    end
    start = 1'b0; abort = 1'b0; tx_ack = 1'b0;
    fin_cnt = int'(bit_cnt);
  endtask

  initial begin
    logic [M-1:0] cb;
    int runs, dat, bsy, fc, ln, ab;
    logic [M-1:0] sig_exp;
    rst = 1'b1; start = 1'b0; abort = 1'b0; tx_ack = 1'b0; cipher_bit = 1'b0;
    seed = '0; len = '0;
    #12;
    chk("rst_cfg_en", cfg_en, 1'b0);
    chk("rst_cfg_bit", cfg_bit, 1'b0);
    chk("rst_run_en", run_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_bit_cnt", bit_cnt, '0);
    chk("rst_tx_req", tx_req, 1'b0);
    chk("rst_tx_ovf", tx_ovf, 1'b0);
    chk("rst_sig", sig, '0);
    rst = 1'b0;

    // TX scheduler directed sequence (edges counted from reset release).
    for (int i = 0; i < 9; i++) cyc();
    chk("tx_pre_tick", tx_req, 1'b0);
    cyc();
    chk("tx_rise", tx_req, 1'b1);
    for (int i = 0; i < 9; i++) cyc();
    tx_ack = 1'b1; cyc();
    chk("tx_ack_on_tick_req", tx_req, 1'b1);
    chk("tx_ack_on_tick_ovf", tx_ovf, 1'b0);
    cyc();
    chk("tx_ack_clear", tx_req, 1'b0);
    cyc();
    chk("tx_ack_idle", tx_req, 1'b0);
    tx_ack = 1'b0;
    for (int i = 0; i < 18; i++) cyc();
    chk("tx_ovf_set", tx_ovf, 1'b1);
    tx_ack = 1'b1; cyc(); tx_ack = 1'b0;
    chk("tx_ovf_clear_req", tx_req, 1'b0);
    for (int i = 0; i < 15; i++) cyc();
    chk("tx_ovf_sticky", tx_ovf, 1'b1);

    session(8'hA5, 5, 0, 1'b0, cb, runs, dat, bsy, fc);
    chk("a5_cfgbits", cb, 8'hA5);
    chk("a5_runs", runs, 5);
    chk("a5_done_at", dat, 14);
    chk("a5_busy_n", bsy, 14);
    chk("a5_bit_cnt", fc, 5);
    idle_cycles(2, 1'b1);

    session(8'h5A, 0, 0, 1'b0, cb, runs, dat, bsy, fc);
    chk("len0_runs", runs, 0);
    chk("len0_done_at", dat, 9);
    chk("len0_bit_cnt", fc, 0);
    idle_cycles(1, 1'b0);

    session(8'hC3, 10, M + 3, 1'b0, cb, runs, dat, bsy, fc);
    chk("abort_runs", runs, 3);
    chk("abort_no_done", dat, 0);
    chk("abort_bit_cnt", fc, 3);
    chk("abort_busy", busy, 1'b0);

    session(8'h81, 4, 0, 1'b1, cb, runs, dat, bsy, fc);
`ifdef XOR_CIPHER_CTRL_SIG_EN
    sig_exp = 8'h0F;
`else
    sig_exp = 8'h00;
`endif
    chk("after_abort_done_at", dat, M + 5);
    chk("sig_all_ones", sig, sig_exp);

    // Asynchronous reset in the middle of LOAD.
    start = 1'b1; seed = 8'hFF; len = 16'd3;
    cyc(); start = 1'b0;
    cyc(); cyc();
    chk("midload_cfg_en", cfg_en, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_cfg_en", cfg_en, 1'b0);
    chk("arst_cfg_bit", cfg_bit, 1'b0);
    chk("arst_run_en", run_en, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_bit_cnt", bit_cnt, '0);
    chk("arst_tx_req", tx_req, 1'b0);
    chk("arst_tx_ovf", tx_ovf, 1'b0);
    chk("arst_sig", sig, '0);
    #2 rst = 1'b0;
    ecnt = 0; m_req = 1'b0; m_ovf = 1'b0;
    session(8'h3C, 3, 0, 1'b0, cb, runs, dat, bsy, fc);
    chk("reload_cfgbits", cb, 8'h3C);
    chk("reload_done_at", dat, M + 4);

    for (int it = 0; it < 25; it++) begin
      ln = $urandom_range(0, 12);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, M + ln) : 0;
      session(M'($urandom), ln, ab, 1'b0, cb, runs, dat, bsy, fc);
      chk("rnd_runs", runs, (ab != 0) ? clampi(ab - M, ln) : ln);
      idle_cycles($urandom_range(0, 3), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
